fe_pow: RTL and testbench

FE_POW -- requirements
Module: fe_pow

---
 rtl/fe_pow_if.sv | 33 +++
 rtl/fe_pow.sv | 139 +++++++++++++
 tb/tb_fe_pow.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fe_pow_if.sv
// fe_pow_if -- request/result and multiplier bus for fe_pow.
//   Request side : z (base), e (exponent), mode (0 = e, 1 = inversion exponent), valid
//   Result side  : out (z^exp), done (1-cycle pulse), busy
//   Multiplier   : mul_op_a/mul_op_b/mul_valid towards the multiplier,
//                  mul_res/mul_done back from it
// slave  = fe_pow view, master = environment (requester + multiplier) view.
interface fe_pow_if #(
    parameter int W  = 320,
    parameter int EW = 255
);
    logic [W-1:0]  z;
    logic [EW-1:0] e;
    logic          mode;
    logic          valid;
    logic [W-1:0]  out;
    logic          done;
    logic          busy;
    logic [W-1:0]  mul_op_a;
    logic [W-1:0]  mul_op_b;
    logic          mul_valid;
    logic [W-1:0]  mul_res;
    logic          mul_done;

    modport slave (
        input  z, e, mode, valid, mul_res, mul_done,
        output out, done, busy, mul_op_a, mul_op_b, mul_valid
    );

    modport master (
        output z, e, mode, valid, mul_res, mul_done,
        input  out, done, busy, mul_op_a, mul_op_b, mul_valid
    );
endinterface

// File: rtl/fe_pow.sv
// fe_pow -- left-to-right square-and-multiply exponentiation over an
// external field multiplier.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fe_pow_if.slave (request, result and multiplier handshake)
// Leading zero exponent bits are skipped in SCAN at one bit per cycle, so
// the first set bit loads acc with z without a multiply.  All outputs are
// registered; multiplier operands only change when a request is issued, so
// they stay stable for the whole multiplier latency.
module fe_pow #(
    parameter int             W       = 320,
    parameter int             EW      = 255,
    parameter logic [W-1:0]   ONE     = W'(1),
    parameter logic [EW-1:0]  EXP_INV = {{(EW-5){1'b1}}, 5'b01011}
) (
    input  logic      clk,
    input  logic      rst,
    fe_pow_if.slave   bus
);
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [2:0] {
        IDLE, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FIN
    } state_t;

    state_t         state_q;
    logic [W-1:0]   z_q;
    logic [EW-1:0]  exp_q;
    logic [IW-1:0]  i_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   out_q;
    logic           done_q;
    logic           busy_q;
    logic [W-1:0]   op_a_q;
    logic [W-1:0]   op_b_q;
    logic           mul_valid_q;

    // exponent bit under the current index
    logic bit_d;
    assign bit_d = exp_q[i_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            z_q         <= '0;
            exp_q       <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mul_valid_q <= 1'b0;
        end else begin
            mul_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy is still high in the done cycle and falls here
                    busy_q <= 1'b0;
                    if (bus.valid) begin
                        z_q     <= bus.z;
                        exp_q   <= bus.mode ? EXP_INV : bus.e;
                        i_q     <= IW'(EW - 1);
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_d) begin
                        acc_q <= z_q;
                        if (i_q == '0) begin
                            state_q <= FIN;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= SQR_REQ;
                        end
                    end else if (i_q == '0) begin
                        // all-zero exponent
                        acc_q   <= ONE;
                        state_q <= FIN;
                    end else begin
                        i_q <= i_q - IW'(1);
                    end
                end
                SQR_REQ: begin
                    op_a_q      <= acc_q;
                    op_b_q      <= acc_q;
                    mul_valid_q <= 1'b1;
                    state_q     <= SQR_WAIT;
                end
                SQR_WAIT: begin
                    if (bus.mul_done) begin
                        acc_q <= bus.mul_res;
                        if (bit_d) begin
                            state_q <= MUL_REQ;
                        end else if (i_q == '0) begin
                            state_q <= FIN;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= SQR_REQ;
                        end
                    end
                end
                MUL_REQ: begin
                    op_a_q      <= acc_q;
                    op_b_q      <= z_q;
                    mul_valid_q <= 1'b1;
                    state_q     <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (bus.mul_done) begin
                        acc_q <= bus.mul_res;
                        if (i_q == '0) begin
                            state_q <= FIN;
                        end else begin
                            i_q     <= i_q - IW'(1);
                            state_q <= SQR_REQ;
                        end
                    end
                end
                FIN: begin
                    out_q   <= acc_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mul_op_a  = op_a_q;
    assign bus.mul_op_b  = op_b_q;
    assign bus.mul_valid = mul_valid_q;
endmodule

// File: tb/tb_fe_pow.sv
module tb_fe_pow;
    localparam int            W    = 64;
    localparam int            EW   = 8;
    localparam logic [W-1:0]  ONE  = 64'h1;
    localparam logic [EW-1:0] EINV = 8'hEB;  // 1110_1011: msb idx 7, popcount 6

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fe_pow_if #(.W(W), .EW(EW)) bus ();

    fe_pow #(.W(W), .EW(EW), .ONE(ONE), .EXP_INV(EINV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // mock multiplier: product mod 2^64, programmable latency
    int           lat = 3;
    int           pend_cnt = 0;
    logic [W-1:0] pend_res = '0;
    logic         mock_done = 1'b0;
    logic         inj_done = 1'b0;
    logic [W-1:0] req_a[$];
    logic [W-1:0] req_b[$];
    int           ndone = 0;

    assign bus.mul_done = mock_done | inj_done;

    always @(posedge clk) begin
        mock_done <= 1'b0;
        if (bus.mul_valid) begin
            req_a.push_back(bus.mul_op_a);
            req_b.push_back(bus.mul_op_b);
            if (lat <= 1) begin
                mock_done   <= 1'b1;
                bus.mul_res <= bus.mul_op_a * bus.mul_op_b;
            end else begin
                pend_cnt <= lat - 1;
                pend_res <= bus.mul_op_a * bus.mul_op_b;
            end
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                mock_done   <= 1'b1;
                bus.mul_res <= pend_res;
            end
        end
    end

    always @(posedge clk) if (bus.done) ndone <= ndone + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // reference by plain repeated multiplication
    function automatic logic [W-1:0] pow_ref(input logic [W-1:0] z, input int e);
        logic [W-1:0] r;
        r = ONE;
        for (int k = 0; k < e; k++) r = r * z;
        return r;
    endfunction

    // start at a negedge, then wait for done; cyc = edges from the accepting edge
    task automatic run(input logic [W-1:0] z, input logic [EW-1:0] e, input logic mode,
                       input bit poke, output int cyc);
        @(negedge clk);
        bus.z = z; bus.e = e; bus.mode = mode; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 2000) begin
            if (poke && cyc == 4) begin
                bus.valid = 1'b1; bus.z = 64'hDEAD; bus.e = 8'h03; bus.mode = 1'b0;
            end else if (poke && cyc == 5) begin
                bus.valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.valid = 1'b0;
        if (!bus.done) chk("done_timeout", 64'(cyc), 64'(0));
    endtask

    initial begin
        int cyc, b, d0;
        logic [W-1:0] zz;
        bus.z = '0; bus.e = '0; bus.mode = 1'b0; bus.valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out",  bus.out, 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_mvld", 64'(bus.mul_valid), 64'h0);
        chk("rst_opa",  bus.mul_op_a, 64'h0);
        chk("rst_opb",  bus.mul_op_b, 64'h0);

        // mul_done in IDLE is ignored
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        @(negedge clk);
        chk("idle_done_out",  bus.out, 64'h0);
        chk("idle_done_busy", 64'(bus.busy), 64'h0);
        chk("idle_done_dn",   64'(bus.done), 64'h0);

        // e=0 -> ONE, EW+2 cycles, no requests
        lat = 3; b = req_a.size(); d0 = ndone;
        run(64'h1234, 8'h00, 1'b0, 1'b0, cyc);
        chk("e0_out",  bus.out, 64'h1);
        chk("e0_cyc",  64'(cyc), 64'(EW + 2));
        chk("e0_busy_in_done", 64'(bus.busy), 64'h1);
        chk("e0_nmul", 64'(req_a.size() - b), 64'h0);
        @(negedge clk);
        chk("e0_busy_after", 64'(bus.busy), 64'h0);
        chk("e0_ndone", 64'(ndone - d0), 64'h1);

        // e=5, z=3, latency 3: SQR(Z), SQR(Z^2), MUL(Z^4, Z)
        b = req_a.size();
        run(64'd3, 8'd5, 1'b0, 1'b0, cyc);
        chk("e5_out",  bus.out, 64'd243);
        chk("e5_nmul", 64'(req_a.size() - b), 64'd3);
        if (req_a.size() - b == 3) begin
            chk("e5_r0a", req_a[b],   64'd3);
            chk("e5_r0b", req_b[b],   64'd3);
            chk("e5_r1a", req_a[b+1], 64'd9);
            chk("e5_r1b", req_b[b+1], 64'd9);
            chk("e5_r2a", req_a[b+2], 64'd81);
            chk("e5_r2b", req_b[b+2], 64'd3);
        end

        // back-to-back start in the cycle after done: e=0 timing still exact
        run(64'h77, 8'h00, 1'b0, 1'b0, cyc);
        chk("b2b_cyc", 64'(cyc), 64'(EW + 2));
        chk("b2b_out", bus.out, 64'h1);

        // same result at latency 1 and 7; valid while busy ignored
        zz = 64'h0000_0001_0000_0001;
        lat = 1;
        run(zz, 8'd5, 1'b0, 1'b0, cyc);
        chk("l1_out", bus.out, 64'h0000_0005_0000_0001);
        lat = 7; b = req_a.size();
        run(zz, 8'd5, 1'b0, 1'b1, cyc);
        chk("l7_out",  bus.out, 64'h0000_0005_0000_0001);
        chk("l7_nmul", 64'(req_a.size() - b), 64'd3);
        if (req_a.size() - b == 3) chk("l7_mul_b", req_b[b+2], zz);
        @(negedge clk);
        chk("l7_idle_busy", 64'(bus.busy), 64'h0);

        // e=1: out=z, no requests; e=2: single squaring
        lat = 2; b = req_a.size();
        run(64'hABCD, 8'd1, 1'b0, 1'b0, cyc);
        chk("e1_out",  bus.out, 64'hABCD);
        chk("e1_nmul", 64'(req_a.size() - b), 64'd0);
        b = req_a.size();
        run(64'd7, 8'd2, 1'b0, 1'b0, cyc);
        chk("e2_out",  bus.out, 64'd49);
        chk("e2_nmul", 64'(req_a.size() - b), 64'd1);

        // mode=1 uses EXP_INV=235 (e ignored): 7 sqr + 5 mul
        b = req_a.size();
        run(64'd3, 8'h55, 1'b1, 1'b0, cyc);
        chk("inv_out",  bus.out, pow_ref(64'd3, 235));
        chk("inv_nmul", 64'(req_a.size() - b), 64'd12);

        // all-ones exponent: 7 sqr + 7 mul
        b = req_a.size();
        run(64'd5, 8'hFF, 1'b0, 1'b0, cyc);
        chk("ff_out",  bus.out, pow_ref(64'd5, 255));
        chk("ff_nmul", 64'(req_a.size() - b), 64'd14);

        // reset during MUL_WAIT, stale mul_done afterwards, then e=1
        lat = 7; b = req_a.size();
        @(negedge clk);
        bus.z = 64'd3; bus.e = 8'd5; bus.mode = 1'b0; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        cyc = 0;
        while (req_a.size() - b < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rw_reach_mul", 64'(req_a.size() - b), 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_busy", 64'(bus.busy), 64'h0);
        chk("rw_mvld", 64'(bus.mul_valid), 64'h0);
        chk("rw_out",  bus.out, 64'h0);
        @(negedge clk);
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (8) @(negedge clk);
        chk("rw_stale_busy", 64'(bus.busy), 64'h0);
        chk("rw_stale_out",  bus.out, 64'h0);
        b = req_a.size(); d0 = ndone;
        run(64'h5A5A, 8'd1, 1'b0, 1'b0, cyc);
        chk("rw_new_out", bus.out, 64'h5A5A);
        repeat (3) @(negedge clk);
        chk("rw_ndone", 64'(ndone - d0), 64'd1);
        chk("rw_nmul",  64'(req_a.size() - b), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
